// File: rtl/cache_stats_reporter.sv
// Snapshots the cache statistics counters, computes three permille hit rates
// with a shared restoring divider, then streams ten words over valid/ready.
module cache_stats_reporter #(
    parameter int CNT_W = 32,
    parameter int SCALE = 1000,
    parameter int DIV_W = CNT_W + 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             snap_req,
    input  logic [CNT_W-1:0] i_accesses,
    input  logic [CNT_W-1:0] i_hits,
    input  logic [CNT_W-1:0] d_reads,
    input  logic [CNT_W-1:0] d_writes,
    input  logic [CNT_W-1:0] d_read_hits,
    input  logic [CNT_W-1:0] d_write_hits,
    input  logic [CNT_W-1:0] total_stall_cycles,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_data,
    output logic [3:0]       out_id,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       snap_dropped
);

    localparam int BC_W = $clog2(DIV_W + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DIV_W - 1);

    typedef enum logic [1:0] {IDLE, DIV, SEND} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0] snap [7];
    logic [CNT_W-1:0] rate0, rate1, rate2;
    logic [DIV_W-1:0] dvd, quo, quo_nx;
    logic [CNT_W-1:0] dvsr, rem, rem_nx;
    logic [CNT_W:0]   rem_sh, rem_diff;
    logic             q_bit;
    logic [BC_W-1:0]  bit_cnt;
    logic [1:0]       div_idx;
    logic [CNT_W-1:0] res_word;
    logic             div_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    assign div_done = (bit_cnt == LAST_BIT);

    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (snap_req) state_nx = DIV;
            end
            DIV: begin
                if (div_done && div_idx == 2'd2) state_nx = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && out_id == 4'd9) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        rem_sh   = {rem, dvd[DIV_W-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        q_bit    = (rem_sh >= {1'b0, dvsr});
        rem_nx   = q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        quo_nx   = {quo[DIV_W-2:0], q_bit};
        res_word = '0;
        if (dvsr == '0) begin
            res_word[31] = 1'b1;
        end else if (quo_nx > DIV_W'(SCALE)) begin
            res_word[30]  = 1'b1;
            res_word[9:0] = 10'(SCALE);
        end else begin
            res_word[9:0] = quo_nx[9:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 7; i++) snap[i] <= '0;
            rate0        <= '0;
            rate1        <= '0;
            rate2        <= '0;
            dvd          <= '0;
            dvsr         <= '0;
            rem          <= '0;
            quo          <= '0;
            bit_cnt      <= '0;
            div_idx      <= '0;
            out_id       <= '0;
            snap_dropped <= '0;
        end else begin
            if (snap_req && state != IDLE && snap_dropped != 8'hFF)
                snap_dropped <= snap_dropped + 8'd1;
            case (state)
                IDLE: begin
                    if (snap_req) begin
                        snap[0] <= i_accesses;
                        snap[1] <= i_hits;
                        snap[2] <= d_reads;
                        snap[3] <= d_writes;
                        snap[4] <= d_read_hits;
                        snap[5] <= d_write_hits;
                        snap[6] <= total_stall_cycles;
                        // First division loads from the live inputs so DIV starts next cycle.
                        dvd     <= DIV_W'(i_hits) * DIV_W'(SCALE);
                        dvsr    <= i_accesses;
                        rem     <= '0;
                        quo     <= '0;
                        bit_cnt <= '0;
                        div_idx <= '0;
                        out_id  <= '0;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        case (div_idx)
                            2'd0:    rate0 <= res_word;
                            2'd1:    rate1 <= res_word;
                            default: rate2 <= res_word;
                        endcase
                        rem     <= '0;
                        quo     <= '0;
                        bit_cnt <= '0;
                        div_idx <= div_idx + 2'd1;
                        if (div_idx == 2'd0) begin
                            dvd  <= DIV_W'(snap[4]) * DIV_W'(SCALE);
                            dvsr <= snap[2];
                        end else begin
                            dvd  <= DIV_W'(snap[5]) * DIV_W'(SCALE);
                            dvsr <= snap[3];
                        end
                    end else begin
                        dvd     <= {dvd[DIV_W-2:0], 1'b0};
                        rem     <= rem_nx;
                        quo     <= quo_nx;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) out_id <= (out_id == 4'd9) ? 4'd0 : out_id + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        case (out_id)
            4'd0: out_data = snap[0];
            4'd1: out_data = snap[1];
            4'd2: out_data = snap[2];
            4'd3: out_data = snap[3];
            4'd4: out_data = snap[4];
            4'd5: out_data = snap[5];
            4'd6: out_data = snap[6];
            4'd7: out_data = rate0;
            4'd8: out_data = rate1;
            4'd9: out_data = rate2;
            default: out_data = '0;
        endcase
        out_last = out_valid && (out_id == 4'd9);
    end

endmodule

// File: tb/tb_cache_stats_reporter.sv
// Scoreboard bench for cache_stats_reporter: expected report words are queued
// at snapshot time and popped as the DUT transfers them.
module tb_cache_stats_reporter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        snap_req = 1'b0;
    logic [31:0] ia, ih, dr, dw, drh, dwh, st;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_data;
    logic [3:0]  out_id;
    logic [7:0]  snap_dropped;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [31:0] data; logic [3:0] id; } exp_t;
    exp_t q[$];

    cache_stats_reporter #(.CNT_W(32), .SCALE(1000)) dut (
        .clk(clk), .reset_n(reset_n), .snap_req(snap_req),
        .i_accesses(ia), .i_hits(ih), .d_reads(dr), .d_writes(dw),
        .d_read_hits(drh), .d_write_hits(dwh), .total_stall_cycles(st),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .busy(busy),
        .snap_dropped(snap_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rate(input logic [31:0] h, input logic [31:0] a);
        logic [63:0] qq;
        if (a == 0) return 32'h8000_0000;
        qq = ({32'd0, h} * 64'd1000) / {32'd0, a};
        if (qq > 64'd1000) return 32'h4000_03E8;
        return qq[31:0];
    endfunction

    task automatic set_cnt(input logic [31:0] a, h, r, w, rh, wh, s);
        ia = a; ih = h; dr = r; dw = w; drh = rh; dwh = wh; st = s;
    endtask

    task automatic push_word(input logic [31:0] d, input int id);
        exp_t e;
        e.data = d;
        e.id   = 4'(id);
        q.push_back(e);
    endtask

    // Returns at posedge+1 just after the latch edge.
    task automatic do_snap();
        @(negedge clk);
        snap_req = 1'b1;
        push_word(ia, 0);  push_word(ih, 1);  push_word(dr, 2);  push_word(dw, 3);
        push_word(drh, 4); push_word(dwh, 5); push_word(st, 6);
        push_word(model_rate(ih, ia), 7);
        push_word(model_rate(drh, dr), 8);
        push_word(model_rate(dwh, dw), 9);
        @(posedge clk);
        #1 snap_req = 1'b0;
    endtask

    // Collects n transfers; mode 1 randomises out_ready and checks stall stability.
    task automatic collect(input int mode, input int n, input string tag);
        int got = 0;
        logic stalled = 1'b0;
        logic [31:0] hd;
        logic [3:0] hid;
        exp_t e;
        for (int cyc = 0; cyc < 3000 && got < n; cyc++) begin
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== hd || out_id !== hid) begin
                    fails++;
                    $display("FAIL %s stall_hold: valid=%b data=%h id=%0d, required valid=1 data=%h id=%0d",
                             tag, out_valid, out_data, out_id, hd, hid);
                end
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL %s extra_word: id=%0d data=%h, required none", tag, out_id, out_data);
                    end else begin
                        e = q.pop_front();
                        tests++;
                        if (out_data !== e.data || out_id !== e.id || out_last !== (e.id == 4'd9)) begin
                            fails++;
                            $display("FAIL %s word: id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                                     tag, out_id, out_data, out_last, e.id, e.data, e.id == 4'd9);
                        end
                    end
                    got++;
                end else begin
                    stalled = 1'b1;
                    hd  = out_data;
                    hid = out_id;
                end
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        if (got < n) begin
            tests++; fails++;
            $display("FAIL %s timeout: got %0d words, required %0d", tag, got, n);
        end
    endtask

    task automatic check_idle(input string tag);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after: valid=%b busy=%b, required 0 0", tag, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (out_valid !== 0 || out_last !== 0 || busy !== 0 || out_id !== 0 ||
            out_data !== 0 || snap_dropped !== 0) begin
            fails++;
            $display("FAIL reset_vals: valid=%b last=%b busy=%b id=%0d data=%h drop=%0d, required all 0",
                     out_valid, out_last, busy, out_id, out_data, snap_dropped);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_latency();
        set_cnt(100, 75, 40, 8, 10, 8, 33);
        out_ready = 1'b1;
        do_snap();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_latch: busy=%b, required 1", busy);
        end
        repeat (125) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: valid=%b at edge+125, required 0", out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_first: valid=%b at edge+126, required 1", out_valid);
        end
        collect(0, 10, "basic");
        check_idle("basic");
    endtask

    task automatic test_div_zero();
        set_cnt(64, 16, 0, 5, 0, 2, 7);
        do_snap();
        collect(0, 10, "divzero");
        check_idle("divzero");
    endtask

    task automatic test_saturate_floor();
        set_cnt(3, 5, 9, 7, 9, 6, 1);
        do_snap(); collect(0, 10, "sat");
        set_cnt(3, 1, 7, 1000, 1, 999, 2);
        do_snap(); collect(0, 10, "floor");
        set_cnt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_snap(); collect(0, 10, "wide");
    endtask

    task automatic test_backpressure();
        set_cnt(1234, 1000, 500, 250, 499, 1, 77);
        do_snap();
        collect(1, 10, "bp");
        check_idle("bp");
    endtask

    task automatic test_dropped();
        int k = 0;
        set_cnt(200, 150, 80, 60, 20, 30, 44);
        do_snap();
        set_cnt(1, 1, 1, 1, 1, 1, 1);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            snap_req = 1'b1;
            @(posedge clk); #1 snap_req = 1'b0;
            @(posedge clk); #1;
        end
        while (!out_valid && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 2; i++) begin
            snap_req = 1'b1;
            @(posedge clk); #1 snap_req = 1'b0;
            @(posedge clk); #1;
        end
        tests++;
        if (snap_dropped !== 8'd5) begin
            fails++;
            $display("FAIL dropped_count: snap_dropped=%0d, required 5", snap_dropped);
        end
        collect(0, 10, "dropped");
        check_idle("dropped");
    endtask

    task automatic test_drop_saturation();
        set_cnt(10, 9, 10, 10, 1, 10, 3);
        do_snap();
        snap_req = 1'b1;
        repeat (300) @(posedge clk);
        #1 snap_req = 1'b0;
        tests++;
        if (snap_dropped !== 8'hFF) begin
            fails++;
            $display("FAIL dropped_sat: snap_dropped=%0d, required 255", snap_dropped);
        end
        collect(0, 10, "dropsat");
    endtask

    task automatic test_reset_mid_send();
        set_cnt(50, 25, 30, 20, 15, 5, 9);
        do_snap();
        collect(0, 4, "prereset");
        tests++;
        if (out_valid !== 1'b1 || out_id !== 4'd4) begin
            fails++;
            $display("FAIL pending_id4: valid=%b id=%0d, required 1 4", out_valid, out_id);
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 0 || busy !== 0 || snap_dropped !== 0 || out_id !== 0 || out_data !== 0) begin
            fails++;
            $display("FAIL async_reset: valid=%b busy=%b drop=%0d id=%0d data=%h, required all 0",
                     out_valid, busy, snap_dropped, out_id, out_data);
        end
        q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        set_cnt(900, 450, 70, 3, 69, 2, 123);
        do_snap();
        collect(0, 10, "postreset");
        check_idle("postreset");
    endtask

    initial begin
        out_ready = 1'b0;
        set_cnt(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_latency();
        test_div_zero();
        test_saturate_floor();
        test_backpressure();
        test_dropped();
        test_drop_saturation();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
